// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Two-master Wishbone B4 classic arbiter in front of a single shared slave bus.
// Ownership is granted round-robin on whole bus cycles. Lock keeps ownership
// across cycles. Every hand-over passes through one IDLE cycle. A watchdog
// terminates a strobe the slave never answers with an error to the owner, so a
// missing slave cannot hang a master.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   mN_addr_i/dat_i/sel_i/we_i       master N request (N = 0, 1)
//   mN_cyc_i/stb_i/lock_i            master N cycle control
//   mN_dat_o/ack_o/err_o/rty_o       read data and termination back to master N
//   s_addr_o/dat_o/sel_o/we_o        forwarded request of the current owner
//   s_cyc_o/stb_o/lock_o             forwarded cycle control of the current owner
//   s_dat_i/ack_i/err_i/rty_i        OR-combined slave return path
//   grant_o                          one-hot owner (bit0 = m0, bit1 = m1), 00 idle
//   timeout_o                        one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_lock_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_lock_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_lock_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] WDT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic        last_grant_reg;   // 0 = m0 owned last, 1 = m1 owned last
    logic [15:0] wdt_reg;

    logic [1:0]  m_cyc;
    logic [1:0]  m_lock;
    logic        owning;
    logic        own_sel;          // index of the current owner when owning
    logic        own_active;       // owner has a live strobe on the bus
    logic        slave_term;
    logic        wdt_fire;

    logic [31:0] ret_dat [2];
    logic [1:0]  ret_ack;
    logic [1:0]  ret_err;
    logic [1:0]  ret_rty;

    assign m_cyc  = {m1_cyc_i, m0_cyc_i};
    assign m_lock = {m1_lock_i, m0_lock_i};

    assign owning     = (state_reg != IDLE);
    assign own_sel    = (state_reg == OWN1);
    assign slave_term = s_ack_i | s_err_i | s_rty_i;

    // A strobe only counts as live while the owner also holds cyc; dropping
    // cyc mid-strobe therefore clears the watchdog.
    assign own_active = owning && (own_sel ? (m1_cyc_i && m1_stb_i)
                                           : (m0_cyc_i && m0_stb_i));

    // A real slave termination in the last watchdog cycle wins over the error.
    assign wdt_fire  = own_active && !slave_term && (wdt_reg == WDT_LAST);
    assign timeout_o = wdt_fire;
    assign grant_o   = {state_reg == OWN1, state_reg == OWN0};

    // Request forwarding: a pure mux on the registered owner, zero when idle.
    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_lock_o = 1'b0;
        if (owning) begin
            s_addr_o = own_sel ? m1_addr_i : m0_addr_i;
            s_dat_o  = own_sel ? m1_dat_i  : m0_dat_i;
            s_sel_o  = own_sel ? m1_sel_i  : m0_sel_i;
            s_we_o   = own_sel ? m1_we_i   : m0_we_i;
            s_cyc_o  = own_sel ? m1_cyc_i  : m0_cyc_i;
            s_stb_o  = own_sel ? m1_stb_i  : m0_stb_i;
            s_lock_o = own_sel ? m1_lock_i : m0_lock_i;
        end
    end

    // Return path: only the owner sees the slave; everyone else sees zeros.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic granted;
        assign granted     = owning && (own_sel == 1'(gi));
        assign ret_dat[gi] = granted ? s_dat_i : 32'd0;
        assign ret_ack[gi] = granted && s_ack_i;
        assign ret_err[gi] = granted && (s_err_i || wdt_fire);
        assign ret_rty[gi] = granted && s_rty_i;
    end

    assign m0_dat_o = ret_dat[0];
    assign m0_ack_o = ret_ack[0];
    assign m0_err_o = ret_err[0];
    assign m0_rty_o = ret_rty[0];
    assign m1_dat_o = ret_dat[1];
    assign m1_ack_o = ret_ack[1];
    assign m1_err_o = ret_err[1];
    assign m1_rty_o = ret_rty[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            wdt_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_cyc == 2'b11)
                        state_reg <= last_grant_reg ? OWN0 : OWN1;
                    else if (m_cyc[0])
                        state_reg <= OWN0;
                    else if (m_cyc[1])
                        state_reg <= OWN1;
                end
                OWN0: begin
                    if (!m_cyc[0] && !m_lock[0]) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m_cyc[1] && !m_lock[1]) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (!own_active || slave_term || wdt_fire)
                wdt_reg <= '0;
            else
                wdt_reg <= wdt_reg + 16'd1;
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master Wishbone B4 classic arbiter sharing the single slave bus (UART interface, frequency counter) between the existing control unit (master 0) and a second master such as a debug/DMA engine (master 1). It grants the bus round-robin on whole bus cycles and honours lock to keep ownership across cycles. A watchdog terminates any stalled strobe with an error so a missing slave cannot hang a master. It sits between the masters and the OR-combined slave return path in the top level.

## Interface
Parameters:
- TIMEOUT, 1024, cycles of unanswered strobe before a forced error (2..65535)

Ports:
- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- m0_addr_i / m1_addr_i  in  32  master address
- m0_dat_i / m1_dat_i  in  32  master write data
- m0_we_i, m0_cyc_i, m0_stb_i, m0_lock_i (and m1_ equivalents)  in  1 each  master control
- m0_sel_i / m1_sel_i  in  4  byte selects
- m0_dat_o / m1_dat_o  out  32  read data to master
- m0_ack_o, m0_err_o, m0_rty_o (and m1_ equivalents)  out  1 each  cycle termination to master
- s_addr_o, s_dat_o  out  32  shared slave address / write data
- s_sel_o  out  4  shared byte selects
- s_we_o, s_cyc_o, s_stb_o, s_lock_o  out  1 each  shared slave control
- s_dat_i  in  32  OR-combined slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  OR-combined slave termination
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE, OWN0, OWN1. Registered; reset -> IDLE.
- IDLE: if only mX_cyc_i=1 -> OWNX. Both requesting -> master not granted last (last_grant register, reset value = m1, so m0 wins first contention). Neither -> stay IDLE.
- OWNX: hold while mX_cyc_i=1 or mX_lock_i=1. When both are 0 -> IDLE; update last_grant=X. No re-arbitration directly OWN0->OWN1; always passes through IDLE (one dead cycle).
- Forwarding (combinational from state): in OWNX, s_* = mX_* inputs; s_cyc_o = mX_cyc_i (not forced high while only lock holds). In IDLE all s_* outputs 0.
- Return path: owner gets s_dat_i, s_ack_i, s_err_i, s_rty_i; non-owner gets dat 0 and ack/err/rty 0. In IDLE both masters see all zeros.
- Watchdog: 16-bit counter wdt; clears when not owning, when owner stb=0, or on any s_ack_i/s_err_i/s_rty_i. Otherwise increments. When wdt == TIMEOUT-1 and slave still silent: owner sees err_o=1 for that cycle (ack/rty 0), timeout_o=1, wdt clears. s_stb_o remains driven by master; master is expected to drop stb.
- Simultaneous slave ack and watchdog fire: slave termination wins, no timeout_o.
- Slave asserting ack with owner stb=0: passed through unchanged (slave error; not filtered).
- Owner drops cyc mid-strobe without termination: grant released per rules, wdt cleared.

## Timing
- Reset values: state IDLE, grant_o=00, timeout_o=0, last_grant=m1, wdt=0; all s_* outputs and master returns 0 (combinational from IDLE).
- Grant latency: cyc rising in cycle N with bus IDLE -> state OWNX from edge N+1; s_cyc_o/s_stb_o visible in cycle N+1.
- Release latency: owner cyc and lock both 0 sampled at edge N -> IDLE in N+1; other waiting master owns in N+2.
- Single-cycle pass-through: slave ack in same cycle as s_stb_o reaches master in that cycle (no added pipeline).
- Watchdog fires exactly TIMEOUT cycles after first unanswered strobe cycle (strobe cycle counts as cycle 1).
- rst_i mid-cycle: next edge forces IDLE, drops all s_* outputs; no termination issued to aborted master.

## Test plan
- Reset: rst_i=1 for 2 cycles with m0_cyc_i=1 -> grant_o=00, s_cyc_o=0; after release grant_o=01 one cycle later.
- Contention: m0 and m1 raise cyc same cycle -> m0 owns; m0 drops cyc after ack -> one IDLE cycle, then grant_o=10; repeat both -> m0 then m1 alternates.
- Lock: m1 owns, does read addr 0x10 then drops cyc with lock=1 while m0 requests -> grant_o stays 10 until m1_lock_i=0, then m0 granted 2 cycles later.
- Isolation: m0 owns, slave returns s_dat_i=0xDEADBEEF with ack -> m0_dat_o=0xDEADBEEF, m0_ack_o=1, m1_dat_o=0, m1_ack_o=0.
- Watchdog: TIMEOUT=8, m0 strobes address with no slave response -> m0_err_o and timeout_o high exactly in 8th strobe cycle, single cycle; with ack arriving in 8th cycle instead -> m0_ack_o=1, m0_err_o=0, timeout_o=0.
- Abort: rst_i asserted while m1 owns with stb high -> next cycle s_stb_o=0, grant_o=00, wdt=0, no ack/err to m1.
